// File: rtl/me_pkg.sv
// Shared constants, FSM encoding and the motion-vector distance helper
// for the me266 minimum-SAD selection path.
package me_pkg;

  localparam int SAD_W  = 14;
  localparam int MV_W   = 4;
  localparam int RANGE  = 7;
  localparam int SIDE   = 2 * RANGE + 1;
  localparam int DIST_W = 5;

  localparam logic [MV_W-1:0]   RANGE_MV = MV_W'(RANGE);
  localparam logic [MV_W-1:0]   LAST_MV  = MV_W'(SIDE - 1);
  localparam logic [SAD_W-1:0]  SAD_MAX  = '1;
  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Manhattan distance of an unsigned window index pair from the centre.
  function automatic logic [DIST_W-1:0] mv_dist(input logic [MV_W-1:0] a,
                                                input logic [MV_W-1:0] b);
    logic [MV_W-1:0] da;
    logic [MV_W-1:0] db;
    da = (a >= RANGE_MV) ? (a - RANGE_MV) : (RANGE_MV - a);
    db = (b >= RANGE_MV) ? (b - RANGE_MV) : (RANGE_MV - b);
    return {1'b0, da} + {1'b0, db};
  endfunction

endpackage

// File: rtl/min_sad_select_if.sv
// SAD stream in / best-vector result out, grouped for the selector and its driver.
interface min_sad_select_if;
  import me_pkg::*;

  logic             blk_start;
  logic             sad_valid;
  logic [SAD_W-1:0] sad_in;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [MV_W-1:0]  best_x;
  logic [MV_W-1:0]  best_y;

  modport master (
    output blk_start, sad_valid, sad_in,
    input  busy, done, best_sad, best_x, best_y
  );

  modport slave (
    input  blk_start, sad_valid, sad_in,
    output busy, done, best_sad, best_x, best_y
  );

endinterface

// File: rtl/sad_cmp_unit.sv
// Decides whether a candidate replaces the working minimum: lower SAD wins,
// an equal SAD wins only when strictly nearer the zero vector.
module sad_cmp_unit
  import me_pkg::*;
(
  input  logic [SAD_W-1:0]  i_sad,
  input  logic [DIST_W-1:0] i_dist,
  input  logic [SAD_W-1:0]  i_work_sad,
  input  logic [DIST_W-1:0] i_work_dist,
  output logic              o_take_new
);

  assign o_take_new = (i_sad < i_work_sad) ||
                      ((i_sad == i_work_sad) && (i_dist < i_work_dist));

endmodule

// File: rtl/min_sad_select.sv
// Full-search minimum-SAD tracker: walks the raster window, keeps the best
// candidate, and publishes it with a one-cycle done pulse at end of window.
module min_sad_select
  import me_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  min_sad_select_if.slave bus
);

  state_e r_state;
  state_e w_next;

  logic [MV_W-1:0]   r_cx;
  logic [MV_W-1:0]   r_cy;
  logic [SAD_W-1:0]  r_work_sad;
  logic [MV_W-1:0]   r_work_x;
  logic [MV_W-1:0]   r_work_y;
  logic [DIST_W-1:0] r_work_dist;

  logic [SAD_W-1:0]  r_best_sad;
  logic [MV_W-1:0]   r_best_x;
  logic [MV_W-1:0]   r_best_y;
  logic              r_done;

  logic [DIST_W-1:0] w_dist;
  logic              w_accept;
  logic              w_last;
  logic              w_take_new;
  logic              w_busy;

  assign w_dist   = mv_dist(r_cx, r_cy);
  assign w_accept = (r_state == ST_SCAN) && bus.sad_valid;
  assign w_last   = w_accept && (r_cx == LAST_MV) && (r_cy == LAST_MV);

  sad_cmp_unit u_cmp (
    .i_sad       (bus.sad_in),
    .i_dist      (w_dist),
    .i_work_sad  (r_work_sad),
    .i_work_dist (r_work_dist),
    .o_take_new  (w_take_new)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    unique case (r_state)
      ST_IDLE: if (bus.blk_start) w_next = ST_SCAN;
      ST_SCAN: begin
        w_busy = 1'b1;
        // A restart outranks completion; coincident completion still publishes.
        if (bus.blk_start)  w_next = ST_SCAN;
        else if (w_last)    w_next = ST_DONE;
      end
      ST_DONE: w_next = bus.blk_start ? ST_SCAN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_work_sad  <= '0;
      r_work_x    <= '0;
      r_work_y    <= '0;
      r_work_dist <= '0;
    end else if (bus.blk_start) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_work_sad  <= SAD_MAX;
      r_work_x    <= RANGE_MV;
      r_work_y    <= RANGE_MV;
      r_work_dist <= DIST_MAX;
    end else if (w_accept) begin
      if (w_take_new) begin
        r_work_sad  <= bus.sad_in;
        r_work_x    <= r_cx;
        r_work_y    <= r_cy;
        r_work_dist <= w_dist;
      end
      if (r_cx == LAST_MV) begin
        r_cx <= '0;
        r_cy <= (r_cy == LAST_MV) ? '0 : r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

  // The last candidate is folded in here directly, so best_* are valid in
  // the same cycle that done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_sad <= '0;
      r_best_x   <= '0;
      r_best_y   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_best_sad <= w_take_new ? bus.sad_in : r_work_sad;
        r_best_x   <= w_take_new ? r_cx       : r_work_x;
        r_best_y   <= w_take_new ? r_cy       : r_work_y;
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.best_sad = r_best_sad;
  assign bus.best_x   = r_best_x;
  assign bus.best_y   = r_best_y;

endmodule

// File: tb/tb_min_sad_select.sv
// Directed bench for min_sad_select: hand-computed windows, aborts, reset and
// back-to-back restarts, each result checked by immediate assertion.
module tb_min_sad_select;
  import me_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  min_sad_select_if intf ();

  min_sad_select dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_done   = 0;
  int n_glitch = 0;
  logic [SAD_W+2*MV_W-1:0] prev_best;

  // best_* may only change on a done cycle.
  always @(negedge clk) begin
    if (intf.done) n_done++;
    else if ({intf.best_sad, intf.best_x, intf.best_y} !== prev_best) n_glitch++;
    prev_best = {intf.best_sad, intf.best_x, intf.best_y};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_best(input string tag, input int s, input int x, input int y);
    check({tag, "_sad"}, 32'(intf.best_sad), s);
    check({tag, "_x"},   32'(intf.best_x),   x);
    check({tag, "_y"},   32'(intf.best_y),   y);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SAD_W-1:0] pat(input int mode, input int x, input int y);
    case (mode)
      0: return (x == 3 && y == 11) ? 14'd20 : 14'd500;
      1: return 14'd300;
      2: return ((x == 0 && y == 0) || (x == 14 && y == 14)) ? 14'd80 : 14'd300;
      3: return (x == 14 && y == 14) ? 14'd0 : 14'd1000;
      4: return (x == 2 && y == 2) ? 14'd5 : 14'd700;
      5: return 14'd900;
      6: return (x == 9 && y == 4) ? 14'd42 : 14'd600;
      7: return (x == 5 && y == 5) ? 14'd10 : 14'd200;
      default: return 14'd0;
    endcase
  endfunction

  task automatic start_block();
    intf.blk_start = 1'b1;
    intf.sad_valid = 1'b0;
    tick();
    intf.blk_start = 1'b0;
  endtask

  // Feed raster candidates [first, last_excl); gaps only ever precede a sample.
  task automatic feed(input int mode, input int first, input int last_excl,
                      input bit gapped, input bit coincide);
    for (int i = first; i < last_excl; i++) begin
      if (gapped) begin
        int unsigned g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          intf.sad_valid = 1'b0;
          tick();
        end
      end
      intf.sad_valid = 1'b1;
      intf.sad_in    = pat(mode, i % SIDE, i / SIDE);
      intf.blk_start = coincide && (i == SIDE * SIDE - 1);
      tick();
      intf.sad_valid = 1'b0;
      intf.blk_start = 1'b0;
    end
  endtask

  initial begin
    int d0;
    int g0;
    rst            = 1'b1;
    intf.blk_start = 1'b0;
    intf.sad_valid = 1'b0;
    intf.sad_in    = '0;
    repeat (3) tick();
    check("rst_busy", 32'(intf.busy), 0);
    check("rst_done", 32'(intf.done), 0);
    check_best("rst", 0, 0, 0);
    rst = 1'b0;
    tick();

    // Single strong minimum; done must land exactly 226 cycles after blk_start.
    d0 = n_done;
    start_block();
    feed(0, 0, 224, 1'b0, 1'b0);
    check("t2_pre_done", 32'(intf.done), 0);
    check("t2_pre_busy", 32'(intf.busy), 1);
    feed(0, 224, 225, 1'b0, 1'b0);
    check("t2_done", 32'(intf.done), 1);
    check_best("t2", 20, 3, 11);
    tick();
    check("t2_pulse", 32'(intf.done), 0);
    check("t2_busy_idle", 32'(intf.busy), 0);
    check("t2_ndone", 32'(n_done), 32'(d0 + 1));

    // Synchronous reset in the middle of a window.
    d0 = n_done;
    start_block();
    feed(1, 0, 100, 1'b0, 1'b0);
    intf.sad_valid = 1'b1;
    intf.sad_in    = 14'd1;
    rst            = 1'b1;
    tick();
    rst = 1'b0;
    check("t1_busy", 32'(intf.busy), 0);
    check("t1_done", 32'(intf.done), 0);
    check_best("t1", 0, 0, 0);
    repeat (20) tick();
    intf.sad_valid = 1'b0;
    tick();
    check("t1_idle_busy", 32'(intf.busy), 0);
    check("t1_ndone", 32'(n_done), 32'(d0));
    check_best("t1_after", 0, 0, 0);
    g0 = n_glitch;

    // Flat window: tie resolves to the centre.
    start_block();
    feed(1, 0, 225, 1'b0, 1'b0);
    check("t3a_done", 32'(intf.done), 1);
    check_best("t3a", 300, 7, 7);
    tick();

    // Two equal-distance minima: the earlier one is kept.
    start_block();
    feed(2, 0, 225, 1'b0, 1'b0);
    check("t3b_done", 32'(intf.done), 1);
    check_best("t3b", 80, 0, 0);
    tick();

    // Minimum on the very last candidate.
    start_block();
    feed(3, 0, 224, 1'b0, 1'b0);
    check("t4_pre_done", 32'(intf.done), 0);
    feed(3, 224, 225, 1'b0, 1'b0);
    check("t4_done", 32'(intf.done), 1);
    check_best("t4", 0, 14, 14);
    tick();
    check("t4_pulse", 32'(intf.done), 0);

    // Abort at candidate 50 after a small minimum, then a fresh flat window.
    d0 = n_done;
    start_block();
    feed(4, 0, 50, 1'b0, 1'b0);
    intf.blk_start = 1'b1;
    tick();
    intf.blk_start = 1'b0;
    check("t5_abort_busy", 32'(intf.busy), 1);
    check("t5_abort_done", 32'(intf.done), 0);
    check_best("t5_hold", 0, 14, 14);
    feed(5, 0, 225, 1'b0, 1'b0);
    check("t5_done", 32'(intf.done), 1);
    check_best("t5", 900, 7, 7);
    tick();
    check("t5_ndone", 32'(n_done), 32'(d0 + 1));

    // Gapped input with a restart coincident with the last sample.
    d0 = n_done;
    start_block();
    feed(6, 0, 225, 1'b1, 1'b1);
    check("t6a_done", 32'(intf.done), 1);
    check("t6a_busy", 32'(intf.busy), 1);
    check_best("t6a", 42, 9, 4);
    feed(7, 0, 225, 1'b1, 1'b0);
    check("t6b_done", 32'(intf.done), 1);
    check("t6b_busy", 32'(intf.busy), 0);
    check_best("t6b", 10, 5, 5);
    tick();
    check("t6_pulse", 32'(intf.done), 0);
    check("t6_ndone", 32'(n_done), 32'(d0 + 2));
    check("best_stable", 32'(n_glitch), 32'(g0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
